// File: rtl/msk_rx_frame_ctrl.sv
// MSK receive frame controller: error/polarity tolerant sync hunt, length byte,
// MSB-first payload packing and a 2-entry valid/ready output buffer.
module msk_rx_frame_ctrl #(
  parameter int unsigned SYNC_W    = 32,
  parameter logic [31:0] SYNC_WORD = 32'h1ACF_FC1D,
  parameter int unsigned MAX_ERR   = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable_i,
  input  logic             bit_i,
  input  logic             bit_valid_i,
  output logic [7:0]       byte_o,
  output logic             byte_valid_o,
  input  logic             byte_ready_i,
  output logic             sof_o,
  output logic             eof_o,
  output logic             sync_lock_o,
  output logic             invert_o,
  output logic             overflow_o,
  output logic [CNT_W-1:0] frame_cnt_o,
  output logic [CNT_W-1:0] len_err_cnt_o
);

  localparam int unsigned       FillW    = $clog2(SYNC_W + 1);
  localparam logic [FillW-1:0]  FillMax  = FillW'(SYNC_W);
  localparam logic [FillW-1:0]  FillLast = FillW'(SYNC_W - 1);
  localparam logic [5:0]        MaxErr   = 6'(MAX_ERR);
  localparam logic [SYNC_W-1:0] SyncPat  = SYNC_WORD[SYNC_W-1:0];

  localparam logic [1:0] StHunt    = 2'd0;
  localparam logic [1:0] StLen     = 2'd1;
  localparam logic [1:0] StPayload = 2'd2;

  logic [1:0]        state;
  // Oldest bit of the window is never needed again after the compare, so only
  // SYNC_W-1 history bits are kept; nxt supplies the full window.
  logic [SYNC_W-2:0] sr;
  logic [SYNC_W-1:0] nxt;
  logic [FillW-1:0]  fill_cnt;
  logic              invert;
  logic [2:0]        bit_cnt;
  logic [6:0]        shift;
  logic [7:0]        shift_nxt;
  logic [7:0]        rem_cnt;
  logic              first_byte;
  logic              overflow;
  logic [CNT_W-1:0]  frame_cnt;
  logic [CNT_W-1:0]  len_err_cnt;

  logic [5:0] dist_pos;
  logic [5:0] dist_neg;
  logic       hit_pos;
  logic       hit_neg;
  logic       fill_ok;
  logic       data_bit;

  logic       push;
  logic       pop;
  logic       full;
  logic       do_write;
  logic       drop;
  logic [7:0] fifo_byte [2];
  logic       fifo_sof  [2];
  logic       fifo_eof  [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] count;

  // Sync window, Hamming distances to both polarities, and the payload bit path
  always_comb begin
    nxt      = {sr, bit_i};
    dist_pos = '0;
    dist_neg = '0;
    for (int i = 0; i < int'(SYNC_W); i++) begin
      dist_pos = dist_pos + 6'(nxt[i] ^ SyncPat[i]);
      dist_neg = dist_neg + 6'(nxt[i] ~^ SyncPat[i]);
    end
    fill_ok   = (fill_cnt >= FillLast);
    hit_pos   = fill_ok && (dist_pos <= MaxErr);
    hit_neg   = fill_ok && (dist_neg <= MaxErr);
    data_bit  = bit_i ^ invert;
    shift_nxt = {shift, data_bit};
  end

  // Buffer push/pop decisions; a full buffer still accepts when it pops
  always_comb begin
    push     = enable_i && bit_valid_i && (state == StPayload) && (bit_cnt == 3'd7);
    full     = (count == 2'd2);
    pop      = byte_valid_o && byte_ready_i;
    do_write = push && (!full || pop);
    drop     = push && full && !pop;
  end

  // Frame control FSM, bit/byte counters and statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= StHunt;
      sr          <= '0;
      fill_cnt    <= '0;
      invert      <= 1'b0;
      bit_cnt     <= '0;
      shift       <= '0;
      rem_cnt     <= '0;
      first_byte  <= 1'b0;
      overflow    <= 1'b0;
      frame_cnt   <= '0;
      len_err_cnt <= '0;
    end else if (!enable_i) begin
      state    <= StHunt;
      sr       <= '0;
      fill_cnt <= '0;
      bit_cnt  <= '0;
    end else if (bit_valid_i) begin
      case (state)
        StHunt: begin
          sr <= nxt[SYNC_W-2:0];
          if (fill_cnt != FillMax) fill_cnt <= fill_cnt + FillW'(1);
          if (hit_pos || hit_neg) begin
            state    <= StLen;
            invert   <= !hit_pos;
            overflow <= 1'b0;
            bit_cnt  <= '0;
          end
        end
        StLen: begin
          shift   <= shift_nxt[6:0];
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (shift_nxt == 8'd0) begin
              len_err_cnt <= len_err_cnt + CNT_W'(1);
              state       <= StHunt;
              sr          <= '0;
              fill_cnt    <= '0;
            end else begin
              state      <= StPayload;
              rem_cnt    <= shift_nxt;
              first_byte <= 1'b1;
            end
          end
        end
        StPayload: begin
          shift   <= shift_nxt[6:0];
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            first_byte <= 1'b0;
            rem_cnt    <= rem_cnt - 8'd1;
            if (drop) overflow <= 1'b1;
            // Dropped bytes still count toward completion
            if (rem_cnt == 8'd1) begin
              frame_cnt <= frame_cnt + CNT_W'(1);
              state     <= StHunt;
              sr        <= '0;
              fill_cnt  <= '0;
            end
          end
        end
        default: state <= StHunt;
      endcase
    end
  end

  // Two-entry output buffer; disable flushes it
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_byte[i] <= 8'd0;
        fifo_sof[i]  <= 1'b0;
        fifo_eof[i]  <= 1'b0;
      end
    end else if (!enable_i) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_write) begin
        fifo_byte[wr_ptr] <= shift_nxt;
        fifo_sof[wr_ptr]  <= first_byte;
        fifo_eof[wr_ptr]  <= (rem_cnt == 8'd1);
        wr_ptr            <= !wr_ptr;
      end
      if (pop) rd_ptr <= !rd_ptr;
      if (do_write && !pop)      count <= count + 2'd1;
      else if (!do_write && pop) count <= count - 2'd1;
    end
  end

  // Head-entry outputs and status
  always_comb begin
    byte_valid_o  = (count != 2'd0);
    byte_o        = fifo_byte[rd_ptr];
    sof_o         = byte_valid_o && fifo_sof[rd_ptr];
    eof_o         = byte_valid_o && fifo_eof[rd_ptr];
    sync_lock_o   = (state == StLen) || (state == StPayload);
    invert_o      = invert;
    overflow_o    = overflow;
    frame_cnt_o   = frame_cnt;
    len_err_cnt_o = len_err_cnt;
  end

endmodule

// File: tb/tb_msk_rx_frame_ctrl.sv
// Self-checking bench for msk_rx_frame_ctrl: directed scenarios plus randomized
// frames checked against a frame-level expectation queue.
module tb_msk_rx_frame_ctrl;

  localparam logic [31:0] SYNC    = 32'h1ACF_FC1D;
  localparam int          MAX_ERR = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable_i;
  logic        bit_i;
  logic        bit_valid_i;
  logic [7:0]  byte_o;
  logic        byte_valid_o;
  logic        byte_ready_i;
  logic        sof_o;
  logic        eof_o;
  logic        sync_lock_o;
  logic        invert_o;
  logic        overflow_o;
  logic [15:0] frame_cnt_o;
  logic [15:0] len_err_cnt_o;

  msk_rx_frame_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .enable_i      (enable_i),
    .bit_i         (bit_i),
    .bit_valid_i   (bit_valid_i),
    .byte_o        (byte_o),
    .byte_valid_o  (byte_valid_o),
    .byte_ready_i  (byte_ready_i),
    .sof_o         (sof_o),
    .eof_o         (eof_o),
    .sync_lock_o   (sync_lock_o),
    .invert_o      (invert_o),
    .overflow_o    (overflow_o),
    .frame_cnt_o   (frame_cnt_o),
    .len_err_cnt_o (len_err_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] b;
    logic       sof;
    logic       eof;
  } rec_t;

  rec_t       exp_q[$];
  logic [7:0] tx_q[$];
  int         checks = 0;
  int         errors = 0;
  int         ready_mode = 1;  // 0: never ready, 1: always, 2: random with bounded stall
  int         stall = 0;
  bit         gap_en = 1'b0;
  int         exp_frames = 0;
  int         exp_len_err = 0;

  // Consumer: choose ready for the coming edge, then score any handshake
  always @(negedge clk) begin
    rec_t e;
    case (ready_mode)
      0: byte_ready_i = 1'b0;
      1: byte_ready_i = 1'b1;
      default: begin
        if (stall >= 2 || $urandom_range(0, 2) == 0) begin
          byte_ready_i = 1'b1;
          stall = 0;
        end else begin
          byte_ready_i = 1'b0;
          stall++;
        end
      end
    endcase
    if (!reset && byte_valid_o && byte_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_byte: got %h sof=%b eof=%b, expected none",
                 byte_o, sof_o, eof_o);
      end else begin
        e = exp_q.pop_front();
        if ({byte_o, sof_o, eof_o} !== {e.b, e.sof, e.eof}) begin
          errors++;
          $display("FAIL byte_out: got %h sof=%b eof=%b, expected %h sof=%b eof=%b",
                   byte_o, sof_o, eof_o, e.b, e.sof, e.eof);
        end
      end
    end
  end

  function automatic bit win_hit(input logic [31:0] w);
    return ($countones(w ^ SYNC) <= MAX_ERR) || ($countones(w ^ ~SYNC) <= MAX_ERR);
  endfunction

  function automatic logic [31:0] gen_mask(input int n);
    logic [31:0] m;
    m = '0;
    while ($countones(m) < n) m[$urandom_range(0, 31)] = 1'b1;
    return m;
  endfunction

  task automatic send_bit(input logic b);
    @(negedge clk);
    if (gap_en && $urandom_range(0, 3) == 0) begin
      bit_valid_i = 1'b0;
      @(negedge clk);
    end
    bit_i       = b;
    bit_valid_i = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bit_valid_i = 1'b0;
    end
  endtask

  // Length byte and payload from tx_q, optionally queueing expected output
  task automatic send_body(input logic inv, input logic [7:0] len, input bit expect_out);
    rec_t r;
    send_word({24'd0, len ^ {8{inv}}}, 8);
    for (int i = 0; i < int'(len); i++) begin
      if (expect_out) begin
        r.b   = tx_q[i];
        r.sof = (i == 0);
        r.eof = (i == int'(len) - 1);
        exp_q.push_back(r);
      end
      send_word({24'd0, tx_q[i] ^ {8{inv}}}, 8);
    end
  endtask

  task automatic send_frame(input logic inv, input logic [31:0] mask, input logic [7:0] len,
                            input bit expect_out);
    send_word((SYNC ^ mask) ^ {32{inv}}, 32);
    send_body(inv, len, expect_out);
  endtask

  task automatic fill_payload(input int n);
    tx_q.delete();
    for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b1;
    enable_i    = 1'b1;
    bit_valid_i = 1'b0;
    bit_i       = 1'b0;
    ready_mode  = 1;
    gap_en      = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    exp_frames  = 0;
    exp_len_err = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({byte_o, byte_valid_o, sof_o, eof_o} !== 11'd0) begin
      errors++;
      $display("FAIL reset_out: got byte=%h v=%b sof=%b eof=%b, expected all 0",
               byte_o, byte_valid_o, sof_o, eof_o);
    end
    checks++;
    if ({sync_lock_o, invert_o, overflow_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_status: got lock=%b inv=%b ovf=%b, expected 000",
               sync_lock_o, invert_o, overflow_o);
    end
    checks++;
    if (frame_cnt_o !== 16'd0 || len_err_cnt_o !== 16'd0) begin
      errors++;
      $display("FAIL reset_counters: got frames=%0d len_err=%0d, expected 0 0",
               frame_cnt_o, len_err_cnt_o);
    end
  endtask

  task automatic test_error_free();
    rec_t r;
    do_reset();
    tx_q = '{8'hA5, 8'h3C, 8'hFF};
    r = '{b: 8'hA5, sof: 1'b1, eof: 1'b0}; exp_q.push_back(r);
    r = '{b: 8'h3C, sof: 1'b0, eof: 1'b0}; exp_q.push_back(r);
    r = '{b: 8'hFF, sof: 1'b0, eof: 1'b1}; exp_q.push_back(r);
    send_word(SYNC, 32);
    @(negedge clk);
    bit_valid_i = 1'b0;
    checks++;
    if (sync_lock_o !== 1'b1 || invert_o !== 1'b0) begin
      errors++;
      $display("FAIL ef_lock: got lock=%b inv=%b, expected 1 0", sync_lock_o, invert_o);
    end
    send_body(1'b0, 8'd3, 1'b0);
    idle(1);
    checks++;
    if (frame_cnt_o !== 16'd1 || sync_lock_o !== 1'b0) begin
      errors++;
      $display("FAIL ef_done: got frames=%0d lock=%b, expected 1 0", frame_cnt_o, sync_lock_o);
    end
    idle(12);
    checks++;
    if (exp_q.size() != 0 || overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL ef_drain: got pending=%0d ovf=%b, expected 0 0", exp_q.size(), overflow_o);
    end
  endtask

  task automatic test_inverted();
    do_reset();
    tx_q = '{8'hA5};
    send_frame(1'b1, 32'd0, 8'd1, 1'b1);
    idle(1);
    checks++;
    if (invert_o !== 1'b1 || frame_cnt_o !== 16'd1 || sync_lock_o !== 1'b0) begin
      errors++;
      $display("FAIL inv_done: got inv=%b frames=%0d lock=%b, expected 1 1 0",
               invert_o, frame_cnt_o, sync_lock_o);
    end
    idle(12);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL inv_drain: got pending=%0d, expected 0", exp_q.size());
    end
  endtask

  task automatic test_error_tolerance();
    logic [31:0] m;
    logic [31:0] hist;
    logic [15:0] r;
    bit          any_hit;
    do_reset();
    fill_payload(2);
    send_word(SYNC ^ gen_mask(2), 32);
    @(negedge clk);
    bit_valid_i = 1'b0;
    checks++;
    if (sync_lock_o !== 1'b1) begin
      errors++;
      $display("FAIL err2_lock: got lock=%b, expected 1", sync_lock_o);
    end
    send_body(1'b0, 8'd2, 1'b1);
    idle(1);
    checks++;
    if (frame_cnt_o !== 16'd1) begin
      errors++;
      $display("FAIL err2_frames: got %0d, expected 1", frame_cnt_o);
    end
    idle(20);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL err2_drain: got pending=%0d, expected 0", exp_q.size());
    end
    // Three bit errors: choose trailing bits so no window can be a legitimate hit
    do_reset();
    m = SYNC ^ gen_mask(3);
    do begin
      r       = 16'($urandom);
      hist    = m;
      any_hit = win_hit(hist);
      for (int i = 15; i >= 0; i--) begin
        hist    = {hist[30:0], r[i]};
        any_hit = any_hit || win_hit(hist);
      end
    end while (any_hit);
    send_word(m, 32);
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      checks++;
      if (sync_lock_o !== 1'b0) begin
        errors++;
        $display("FAIL err3_nolock: bit %0d got lock=%b, expected 0", i, sync_lock_o);
      end
      if (i < 16) begin
        bit_i       = r[15-i];
        bit_valid_i = 1'b1;
      end else begin
        bit_valid_i = 1'b0;
      end
    end
  endtask

  task automatic test_zero_length();
    do_reset();
    send_word(SYNC, 32);
    send_word(32'd0, 8);
    idle(1);
    checks++;
    if (len_err_cnt_o !== 16'd1 || sync_lock_o !== 1'b0 || frame_cnt_o !== 16'd0) begin
      errors++;
      $display("FAIL zl_reject: got len_err=%0d lock=%b frames=%0d, expected 1 0 0",
               len_err_cnt_o, sync_lock_o, frame_cnt_o);
    end
    tx_q = '{8'h5A};
    send_frame(1'b0, 32'd0, 8'd1, 1'b1);
    idle(1);
    checks++;
    if (frame_cnt_o !== 16'd1 || len_err_cnt_o !== 16'd1) begin
      errors++;
      $display("FAIL zl_next: got frames=%0d len_err=%0d, expected 1 1",
               frame_cnt_o, len_err_cnt_o);
    end
    idle(12);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL zl_drain: got pending=%0d, expected 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    rec_t r;
    do_reset();
    ready_mode = 0;
    tx_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_frame(1'b0, 32'd0, 8'd4, 1'b0);
    idle(1);
    checks++;
    if (frame_cnt_o !== 16'd1 || overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_status: got frames=%0d ovf=%b, expected 1 1", frame_cnt_o, overflow_o);
    end
    checks++;
    if (byte_valid_o !== 1'b1 || byte_o !== 8'h11 || sof_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_head: got v=%b byte=%h sof=%b, expected 1 11 1",
               byte_valid_o, byte_o, sof_o);
    end
    r = '{b: 8'h11, sof: 1'b1, eof: 1'b0}; exp_q.push_back(r);
    r = '{b: 8'h22, sof: 1'b0, eof: 1'b0}; exp_q.push_back(r);
    ready_mode = 1;
    idle(6);
    checks++;
    if (exp_q.size() != 0 || byte_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: got pending=%0d v=%b, expected 0 0", exp_q.size(), byte_valid_o);
    end
    send_word(SYNC, 32);
    @(negedge clk);
    bit_valid_i = 1'b0;
    checks++;
    if (overflow_o !== 1'b0 || sync_lock_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_resync: got ovf=%b lock=%b, expected 0 1", overflow_o, sync_lock_o);
    end
    fill_payload(1);
    send_body(1'b0, 8'd1, 1'b1);
    idle(12);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_after: got pending=%0d, expected 0", exp_q.size());
    end
  endtask

  task automatic test_abort();
    do_reset();
    ready_mode = 0;
    fill_payload(3);
    send_word(SYNC, 32);
    send_word(32'd3, 8);
    send_word({24'd0, tx_q[0]}, 8);
    send_word({29'd0, tx_q[1][7:5]}, 3);
    @(negedge clk);
    checks++;
    if (byte_valid_o !== 1'b1 || sync_lock_o !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre: got v=%b lock=%b, expected 1 1", byte_valid_o, sync_lock_o);
    end
    enable_i    = 1'b0;
    bit_i       = 1'($urandom);
    bit_valid_i = 1'b1;
    @(negedge clk);
    enable_i    = 1'b1;
    bit_valid_i = 1'b0;
    checks++;
    if (byte_valid_o !== 1'b0 || sync_lock_o !== 1'b0 || frame_cnt_o !== 16'd0) begin
      errors++;
      $display("FAIL abort_post: got v=%b lock=%b frames=%0d, expected 0 0 0",
               byte_valid_o, sync_lock_o, frame_cnt_o);
    end
    ready_mode = 1;
    fill_payload(2);
    send_frame(1'b0, 32'd0, 8'd2, 1'b1);
    idle(1);
    checks++;
    if (frame_cnt_o !== 16'd1) begin
      errors++;
      $display("FAIL abort_next: got frames=%0d, expected 1", frame_cnt_o);
    end
    idle(12);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_drain: got pending=%0d, expected 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic inv;
    do_reset();
    inv = 1'b0;
    for (int f = 0; f < 3; f++) begin
      inv = 1'($urandom);
      fill_payload($urandom_range(1, 4));
      send_frame(inv, 32'd0, 8'(tx_q.size()), 1'b1);
    end
    idle(1);
    checks++;
    if (frame_cnt_o !== 16'd3 || invert_o !== inv) begin
      errors++;
      $display("FAIL b2b_done: got frames=%0d inv=%b, expected 3 %b", frame_cnt_o, invert_o, inv);
    end
    idle(20);
    checks++;
    if (exp_q.size() != 0 || overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: got pending=%0d ovf=%b, expected 0 0", exp_q.size(), overflow_o);
    end
  endtask

  task automatic test_random();
    int len;
    do_reset();
    ready_mode = 2;
    gap_en     = 1'b1;
    for (int f = 0; f < 10; f++) begin
      len = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 6);
      fill_payload(len);
      send_frame(1'($urandom), gen_mask($urandom_range(0, MAX_ERR)), 8'(len), 1'b1);
      if (len == 0) exp_len_err++;
      else          exp_frames++;
      idle(1);
      checks++;
      if (frame_cnt_o !== 16'(exp_frames) || len_err_cnt_o !== 16'(exp_len_err)) begin
        errors++;
        $display("FAIL rnd_counts: frame %0d got frames=%0d len_err=%0d, expected %0d %0d",
                 f, frame_cnt_o, len_err_cnt_o, exp_frames, exp_len_err);
      end
      idle($urandom_range(0, 5));
    end
    idle(40);
    checks++;
    if (exp_q.size() != 0 || overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL rnd_drain: got pending=%0d ovf=%b, expected 0 0", exp_q.size(), overflow_o);
    end
    gap_en = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    enable_i     = 1'b1;
    bit_i        = 1'b0;
    bit_valid_i  = 1'b0;
    byte_ready_i = 1'b1;
    test_reset();
    test_error_free();
    test_inverted();
    test_error_tolerance();
    test_zero_length();
    test_backpressure();
    test_abort();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
